// File: rtl/register_file_pkg.sv
// Shared sizing and types for the SIWO general-purpose register file.
package register_file_pkg;

    localparam int REG_WIDTH  = 4;
    localparam int DATA_WIDTH = 8;

    typedef logic [REG_WIDTH-1:0]  reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// One asynchronous read port of the SIWO register file: a combinational
// mux from the register array to a single output.
// Optional build macro: SIWO_ZERO_REG_EN (address 0 always reads 0).
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int REG_WIDTH  = register_file_pkg::REG_WIDTH,
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] regs [2**REG_WIDTH],
    input  logic [REG_WIDTH-1:0]  addr,
    output logic [DATA_WIDTH-1:0] value
);

    // Select the addressed register; register 0 is forced to zero when hardwired.
    always_comb begin
        value = regs[addr];
`ifdef SIWO_ZERO_REG_EN
        if (addr == '0) begin
            value = '0;
        end
`endif
    end

endmodule : register_file_read_port

// File: rtl/register_file.sv
// SIWO general-purpose register file: two combinational read ports
// (ALU operands A and B) and one synchronous writeback port.
// Optional build macro: SIWO_ZERO_REG_EN (register 0 hardwired to zero,
// writes to address 0 discarded).
module register_file
    import register_file_pkg::*;
#(
    parameter int REG_WIDTH  = register_file_pkg::REG_WIDTH,
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH
) (
    input  logic                  _CLK,
    input  logic                  _RESET,
    input  logic                  _regWrite,
    input  logic [REG_WIDTH-1:0]  _regSrcA,
    input  logic [REG_WIDTH-1:0]  _regSrcB,
    input  logic [REG_WIDTH-1:0]  _regDest,
    input  logic [DATA_WIDTH-1:0] _writeVal,
    output logic [DATA_WIDTH-1:0] valueA,
    output logic [DATA_WIDTH-1:0] valueB
);

    localparam int unsigned DEPTH = 2**REG_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  writeEn;

    // Qualify the write enable; address 0 is not writable when hardwired.
    always_comb begin
`ifdef SIWO_ZERO_REG_EN
        writeEn = _regWrite && (_regDest != '0);
`else
        writeEn = _regWrite;
`endif
    end

    // Storage: reset clears every register and wins over a same-edge write.
    always_ff @(posedge _CLK) begin
        if (_RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn) begin
            regs[_regDest] <= _writeVal;
        end
    end

    register_file_read_port #(
        .REG_WIDTH  (REG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) readPortA (
        .regs  (regs),
        .addr  (_regSrcA),
        .value (valueA)
    );

    register_file_read_port #(
        .REG_WIDTH  (REG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) readPortB (
        .regs  (regs),
        .addr  (_regSrcB),
        .value (valueB)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by a
// randomized run, all checked against an array-based reference model.
module tb_register_file;
    import register_file_pkg::*;

    localparam int DEPTH = 2**REG_WIDTH;

    logic      clk;
    logic      rst;
    logic      regWrite;
    reg_addr_t regSrcA;
    reg_addr_t regSrcB;
    reg_addr_t regDest;
    data_t     writeVal;
    data_t     valueA;
    data_t     valueB;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: plain array of register contents.
    data_t model [DEPTH];

    register_file #(
        .REG_WIDTH  (REG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        ._CLK      (clk),
        ._RESET    (rst),
        ._regWrite (regWrite),
        ._regSrcA  (regSrcA),
        ._regSrcB  (regSrcB),
        ._regDest  (regDest),
        ._writeVal (writeVal),
        .valueA    (valueA),
        .valueB    (valueB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SIWO_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    // Value a read of address a must return according to the rules.
    function automatic data_t expRead(input int a);
        if (ZERO_REG && a == 0) return '0;
        return model[a];
    endfunction

    // Advance one rising edge, applying the presented inputs to the model.
    task automatic tick();
        bit    r = rst;
        bit    w = regWrite;
        int    d = int'(regDest);
        data_t v = writeVal;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (w) begin
            model[d] = v;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; regWrite = 1'b0;
        tick();
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            regSrcA = reg_addr_t'(a);
            regSrcB = reg_addr_t'(DEPTH - 1 - a);
            #1;
            compared++;
            if (valueA !== 8'h00) begin
                mismatched++;
                $display("FAIL reset_sweepA addr=%0d got=%h exp=00", a, valueA);
            end
            compared++;
            if (valueB !== 8'h00) begin
                mismatched++;
                $display("FAIL reset_sweepB addr=%0d got=%h exp=00", DEPTH - 1 - a, valueB);
            end
        end
    endtask

    task automatic test_basic();
        data_t expB;
        regWrite = 1'b1; regDest = 4'd0; writeVal = 8'd10;
        tick();
        regDest = 4'd2; writeVal = 8'd7;
        tick();
        regWrite = 1'b0; regSrcA = 4'd2; regSrcB = 4'd0;
        #1;
        expB = ZERO_REG ? 8'd0 : 8'd10;
        compared++;
        if (valueA !== 8'd7) begin
            mismatched++;
            $display("FAIL basic_readA got=%0d exp=7", valueA);
        end
        compared++;
        if (valueB !== expB) begin
            mismatched++;
            $display("FAIL basic_readB got=%0d exp=%0d", valueB, expB);
        end
    endtask

    task automatic test_write_disabled();
        regWrite = 1'b0; regDest = 4'd2; writeVal = 8'd11;
        regSrcA = 4'd2; regSrcB = 4'd5;
        tick();
        tick();
        compared++;
        if (valueA !== 8'd7) begin
            mismatched++;
            $display("FAIL wr_disabled_A got=%0d exp=7", valueA);
        end
        compared++;
        if (valueB !== 8'd0) begin
            mismatched++;
            $display("FAIL wr_disabled_B got=%0d exp=0", valueB);
        end
    endtask

    task automatic test_read_during_write();
        regWrite = 1'b1; regDest = 4'd2; writeVal = 8'd55; regSrcA = 4'd2;
        #1;
        compared++;
        if (valueA !== 8'd7) begin
            mismatched++;
            $display("FAIL rdw_before got=%0d exp=7", valueA);
        end
        tick();
        compared++;
        if (valueA !== 8'd55) begin
            mismatched++;
            $display("FAIL rdw_after got=%0d exp=55", valueA);
        end
        regWrite = 1'b0; writeVal = 8'd14;
        tick();
        compared++;
        if (valueA !== 8'd55) begin
            mismatched++;
            $display("FAIL rdw_hold got=%0d exp=55", valueA);
        end
    endtask

    task automatic test_reset_priority();
        regWrite = 1'b1; regDest = 4'd3; writeVal = 8'h33;
        tick();
        rst = 1'b1; regWrite = 1'b1; regDest = 4'd3; writeVal = 8'hAA;
        tick();
        rst = 1'b0; regWrite = 1'b0; regSrcA = 4'd3; regSrcB = 4'd2;
        #1;
        compared++;
        if (valueA !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_prio_reg3 got=%h exp=00", valueA);
        end
        compared++;
        if (valueB !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_prio_reg2 got=%h exp=00", valueB);
        end
    endtask

    task automatic test_alias_sweep();
        data_t exp;
        regWrite = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            regDest = reg_addr_t'(a); writeVal = data_t'(a + 1);
            tick();
        end
        regWrite = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            regSrcA = reg_addr_t'(a); regSrcB = reg_addr_t'(a);
            #1;
            exp = (ZERO_REG && a == 0) ? 8'd0 : data_t'(a + 1);
            compared++;
            if (valueA !== exp) begin
                mismatched++;
                $display("FAIL alias_A addr=%0d got=%0d exp=%0d", a, valueA, exp);
            end
            compared++;
            if (valueB !== exp) begin
                mismatched++;
                $display("FAIL alias_B addr=%0d got=%0d exp=%0d", a, valueB, exp);
            end
        end
    endtask

    task automatic test_random();
        data_t expA, expB;
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 39) == 0);
            regWrite = $urandom_range(0, 2) != 0;
            regDest  = reg_addr_t'($urandom_range(0, DEPTH - 1));
            writeVal = data_t'($urandom_range(0, 255));
            regSrcA  = reg_addr_t'($urandom_range(0, DEPTH - 1));
            regSrcB  = ($urandom_range(0, 3) == 0) ? regDest
                                                   : reg_addr_t'($urandom_range(0, DEPTH - 1));
            #1;
            // Old contents visible before the edge.
            expA = expRead(int'(regSrcA));
            expB = expRead(int'(regSrcB));
            compared++;
            if (valueA !== expA || valueB !== expB) begin
                mismatched++;
                $display("FAIL rand_pre n=%0d A=%h/%h B=%h/%h exp", n, valueA, expA, valueB, expB);
            end
            tick();
            expA = expRead(int'(regSrcA));
            expB = expRead(int'(regSrcB));
            compared++;
            if (valueA !== expA || valueB !== expB) begin
                mismatched++;
                $display("FAIL rand_post n=%0d A=%h/%h B=%h/%h exp", n, valueA, expA, valueB, expB);
            end
        end
        rst = 1'b0; regWrite = 1'b0;
    endtask

    initial begin
        rst = 1'b0; regWrite = 1'b0; regSrcA = '0; regSrcB = '0;
        regDest = '0; writeVal = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_write_disabled();
        test_read_during_write();
        test_reset_priority();
        test_alias_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_register_file
